// File: rtl/axis_frame_fifo.sv
// AXI-Stream FIFO: circular buffer of {tlast, tdata}, first-word-fall-through output.
// Define AXIS_FRAME_FIFO_STORE_FWD_EN to hold output until a whole frame is stored.
module axis_frame_fifo #(
    parameter int DATA_WIDTH = 64,
    parameter int DEPTH      = 16
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         s_axis_tvalid,
    input  logic [DATA_WIDTH-1:0]        s_axis_tdata,
    input  logic                         s_axis_tlast,
    output logic                         s_axis_tready,
    output logic                         m_axis_tvalid,
    output logic [DATA_WIDTH-1:0]        m_axis_tdata,
    output logic                         m_axis_tlast,
    input  logic                         m_axis_tready,
    output logic [$clog2(DEPTH):0]       fill_level,
    output logic [$clog2(DEPTH):0]       frame_count
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_XOR = {1'b1, {AW{1'b0}}};

    logic [DATA_WIDTH:0] mem [DEPTH];
    logic [AW:0]         wr_ptr_q, wr_ptr_d;
    logic [AW:0]         rd_ptr_q, rd_ptr_d;
    logic [AW:0]         frame_cnt_q, frame_cnt_d;
    logic                s_ready_q, s_ready_d;
    logic                full, empty, wr_en, rd_en, m_valid;
    logic [DATA_WIDTH:0] head;
    logic                head_last;

    assign full      = (wr_ptr_q ^ rd_ptr_q) == FULL_XOR;
    assign empty     = (wr_ptr_q == rd_ptr_q);
    assign head      = mem[rd_ptr_q[AW-1:0]];
    assign head_last = head[DATA_WIDTH];

`ifdef AXIS_FRAME_FIFO_STORE_FWD_EN
    logic in_prog_q, in_prog_d;

    // Full with no complete frame stored releases words so the writer cannot deadlock.
    assign m_valid = !empty && ((frame_cnt_q != '0) || full || in_prog_q);

    always_comb begin
        in_prog_d = in_prog_q;
        if (rd_en) in_prog_d = !head_last;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) in_prog_q <= 1'b0;
        else     in_prog_q <= in_prog_d;
    end
`else
    assign m_valid = !empty;
`endif

    // s_ready_q already implies not full, so writes can never overflow.
    assign wr_en = s_axis_tvalid && s_ready_q;
    assign rd_en = m_valid && m_axis_tready;

    always_comb begin
        wr_ptr_d    = wr_ptr_q + {{AW{1'b0}}, wr_en};
        rd_ptr_d    = rd_ptr_q + {{AW{1'b0}}, rd_en};
        frame_cnt_d = frame_cnt_q;
        case ({wr_en && s_axis_tlast, rd_en && head_last})
            2'b10:   frame_cnt_d = frame_cnt_q + 1'b1;
            2'b01:   frame_cnt_d = frame_cnt_q - 1'b1;
            default: frame_cnt_d = frame_cnt_q;
        endcase
        // Ready is registered from the next pointer state, never from m_axis_tready.
        s_ready_d = ((wr_ptr_d ^ rd_ptr_d) != FULL_XOR);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            frame_cnt_q <= '0;
            s_ready_q   <= 1'b0;
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            frame_cnt_q <= frame_cnt_d;
            s_ready_q   <= s_ready_d;
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en) mem[wr_ptr_q[AW-1:0]] <= {s_axis_tlast, s_axis_tdata};
    end

    assign s_axis_tready = s_ready_q;
    assign m_axis_tvalid = m_valid;
    assign m_axis_tdata  = head[DATA_WIDTH-1:0];
    assign m_axis_tlast  = m_valid && head_last;
    assign fill_level    = wr_ptr_q - rd_ptr_q;
    assign frame_count   = frame_cnt_q;
endmodule

// File: tb/tb_axis_frame_fifo.sv
// Directed bench for axis_frame_fifo with a scoreboard on the output stream.
// Builds for either mode; AXIS_FRAME_FIFO_STORE_FWD_EN selects store-and-forward expectations.
module tb_axis_frame_fifo;
  localparam int DW = 64;
  localparam int DEPTH = 16;
  localparam int W = DW + 1;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          s_axis_tvalid = 1'b0;
  logic [DW-1:0] s_axis_tdata = '0;
  logic          s_axis_tlast = 1'b0;
  logic          s_axis_tready;
  logic          m_axis_tvalid;
  logic [DW-1:0] m_axis_tdata;
  logic          m_axis_tlast;
  logic          m_axis_tready = 1'b0;
  logic [4:0]    fill_level;
  logic [4:0]    frame_count;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  logic [W-1:0] exp_q[$];

  axis_frame_fifo #(.DATA_WIDTH(DW), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst),
    .s_axis_tvalid(s_axis_tvalid), .s_axis_tdata(s_axis_tdata),
    .s_axis_tlast(s_axis_tlast), .s_axis_tready(s_axis_tready),
    .m_axis_tvalid(m_axis_tvalid), .m_axis_tdata(m_axis_tdata),
    .m_axis_tlast(m_axis_tlast), .m_axis_tready(m_axis_tready),
    .fill_level(fill_level), .frame_count(frame_count)
  );

  // clock / reset
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // scoreboard: push accepted input words, pop and compare at output handshakes
  always @(negedge clk) begin
    if (!rst) begin
      if (s_axis_tvalid && s_axis_tready) exp_q.push_back({s_axis_tlast, s_axis_tdata});
      if (m_axis_tvalid && m_axis_tready) begin
        if (exp_q.size() == 0) check("unexpected_word", {m_axis_tlast, m_axis_tdata}, 'x);
        else check("out_word", {m_axis_tlast, m_axis_tdata}, exp_q.pop_front());
      end
    end
  end

  // driver tasks
  task automatic send(input logic [DW-1:0] d, input logic l);
    logic ok;
    ok = 1'b0;
    s_axis_tvalid = 1'b1;
    s_axis_tdata = d;
    s_axis_tlast = l;
    for (int i = 0; i < 100 && !ok; i++) begin
      @(negedge clk);
      ok = s_axis_tready;
      @(posedge clk);
      #1;
    end
    if (!ok) check("send_accept", W'(ok), W'(1));
    s_axis_tvalid = 1'b0;
  endtask

  task automatic wait_drain(input string tag);
    for (int i = 0; i < 200; i++) begin
      if (fill_level == 0 && exp_q.size() == 0) break;
      @(posedge clk);
      #1;
    end
    check({tag, "_fill"}, W'(fill_level), W'(0));
    check({tag, "_q"}, W'(exp_q.size()), W'(0));
    check({tag, "_frames"}, W'(frame_count), W'(0));
  endtask

  function automatic logic [DW-1:0] rnd();
    return {$urandom, $urandom};
  endfunction

  initial begin
    logic [DW-1:0] w0;
    int t0;

    // reset state
    repeat (3) @(posedge clk);
    #1;
    check("rst_tready", W'(s_axis_tready), W'(0));
    check("rst_tvalid", W'(m_axis_tvalid), W'(0));
    check("rst_tlast", W'(m_axis_tlast), W'(0));
    check("rst_fill", W'(fill_level), W'(0));
    check("rst_frames", W'(frame_count), W'(0));
    rst = 1'b0;
    @(posedge clk);
    #1;
    check("release_tready", W'(s_axis_tready), W'(1));

    // A, B, C with C ending the frame
    m_axis_tready = 1'b1;
    w0 = rnd();
    send(w0, 1'b0);
`ifdef AXIS_FRAME_FIFO_STORE_FWD_EN
    check("abc_hold", W'(m_axis_tvalid), W'(0));
`else
    check("abc_fwft_valid", W'(m_axis_tvalid), W'(1));
    check("abc_fwft_data", W'(m_axis_tdata), W'(w0));
`endif
    send(rnd(), 1'b0);
    send(rnd(), 1'b1);
    wait_drain("abc");

    // fill to DEPTH with output stalled
    m_axis_tready = 1'b0;
    w0 = rnd();
    send(w0, 1'b0);
    for (int i = 1; i < DEPTH; i++) send(rnd(), 1'b0);
    check("full_tready", W'(s_axis_tready), W'(0));
    check("full_fill", W'(fill_level), W'(DEPTH));
    check("full_valid", W'(m_axis_tvalid), W'(1));
    s_axis_tvalid = 1'b1;
    s_axis_tdata = rnd();
    repeat (2) @(posedge clk);
    #1;
    s_axis_tvalid = 1'b0;
    check("overflow_fill", W'(fill_level), W'(DEPTH));
    check("stall_data", W'(m_axis_tdata), W'(w0));
    m_axis_tready = 1'b1;
    @(posedge clk);
    #1;
    m_axis_tready = 1'b0;
    check("after_read_tready", W'(s_axis_tready), W'(1));
    check("after_read_fill", W'(fill_level), W'(DEPTH - 1));

    // streaming with both sides held active, pointers wrap
    m_axis_tready = 1'b1;
    t0 = cyc;
    for (int i = 0; i < 40; i++) send(rnd(), (i == 39));
    check("stream_rate", W'((cyc - t0) <= 80), W'(1));
    wait_drain("stream");

`ifdef AXIS_FRAME_FIFO_STORE_FWD_EN
    // frame held until its tlast is stored
    for (int i = 0; i < 5; i++) begin
      send(rnd(), 1'b0);
      check("sf_hold", W'(m_axis_tvalid), W'(0));
    end
    send(rnd(), 1'b1);
    check("sf_release", W'(m_axis_tvalid), W'(1));
    check("sf_frames", W'(frame_count), W'(1));
    wait_drain("sf_frame");
    // full without tlast releases cut-through
    for (int i = 0; i < DEPTH - 1; i++) send(rnd(), 1'b0);
    check("sf_nofull_hold", W'(m_axis_tvalid), W'(0));
    send(rnd(), 1'b0);
    check("sf_full_release", W'(m_axis_tvalid), W'(1));
    wait_drain("sf_full");
`else
    m_axis_tready = 1'b0;
    send(rnd(), 1'b0);
    check("ct_valid", W'(m_axis_tvalid), W'(1));
    for (int i = 1; i < DEPTH; i++) send(rnd(), 1'b0);
    m_axis_tready = 1'b1;
    wait_drain("ct_full");
`endif

    // reset in the middle of a frame
    m_axis_tready = 1'b0;
    for (int i = 0; i < 7; i++) send(rnd(), 1'b0);
    check("mid_fill", W'(fill_level), W'(7));
    rst = 1'b1;
    #1;
    check("async_tvalid", W'(m_axis_tvalid), W'(0));
    check("async_tready", W'(s_axis_tready), W'(0));
    check("async_tlast", W'(m_axis_tlast), W'(0));
    check("async_fill", W'(fill_level), W'(0));
    check("async_frames", W'(frame_count), W'(0));
    exp_q.delete();
    @(posedge clk);
    #1;
    rst = 1'b0;
    m_axis_tready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk);
      #1;
      check("no_stale", W'(m_axis_tvalid), W'(0));
    end
    check("rerelease_tready", W'(s_axis_tready), W'(1));
    send(rnd(), 1'b0);
    send(rnd(), 1'b1);
    wait_drain("post_rst");

    // final report
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/axis_frame_fifo.md
AXIS_FRAME_FIFO -- requirements
Module: axis_frame_fifo

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 64, width of tdata on both ports.
REQ-002 SHALL have parameter DEPTH, default 16, FIFO capacity in words; power of two, >= 4.
REQ-003 SHALL have port clk  input  1  single clock, all state on rising edge.
REQ-004 SHALL have port rst  input  1  reset; asynchronous, active-high.
REQ-005 SHALL have port s_axis_tvalid  input  1  upstream word valid (from arbitrated join stream).
REQ-006 SHALL have port s_axis_tdata  input  DATA_WIDTH  upstream word.
REQ-007 SHALL have port s_axis_tlast  input  1  upstream end-of-frame marker.
REQ-008 SHALL have port s_axis_tready  output  1  FIFO can accept a word.
REQ-009 SHALL have port m_axis_tvalid  output  1  downstream word valid.
REQ-010 SHALL have port m_axis_tdata  output  DATA_WIDTH  downstream word.
REQ-011 SHALL have port m_axis_tlast  output  1  downstream end-of-frame marker.
REQ-012 SHALL have port m_axis_tready  input  1  downstream accepts word.
REQ-013 SHALL have port fill_level  output  log2(DEPTH)+1  words currently stored.
REQ-014 SHALL have port frame_count  output  log2(DEPTH)+1  tlast-marked words currently stored.

Function
REQ-015 SHALL store {tlast, tdata} per entry in a DEPTH-entry circular buffer with log2(DEPTH)+1-bit read/write pointers; full when pointers differ only in MSB, empty when equal.
REQ-016 SHALL write on s_axis_tvalid && s_axis_tready; read on m_axis_tvalid && m_axis_tready.
REQ-017 SHALL drive s_axis_tready = !full, from registered state only (no combinational path from m_axis_tready).
REQ-018 SHALL present head entry first-word-fall-through: word written in cycle N visible at m_axis with m_axis_tvalid high in cycle N+1 (no empty-bypass).
REQ-019 SHALL keep m_axis_tdata/m_axis_tlast stable while m_axis_tvalid && !m_axis_tready.
REQ-020 SHALL, on simultaneous write and read, leave fill_level unchanged; when full, a same-cycle read does not enable a write (tready stays low that cycle).
REQ-021 SHALL wrap pointers modulo 2*DEPTH with no special case at wrap.
REQ-022 SHALL increment frame_count on write with tlast, decrement on read with tlast, unchanged when both occur in one cycle.
REQ-023 SHALL never overflow or underflow: writes ignored when full, reads impossible when empty.
REQ-024 SHALL pass tdata and tlast unmodified and in order.

Reset
REQ-025 SHALL, while rst high, asynchronously clear pointers, fill_level=0, frame_count=0, s_axis_tready=0, m_axis_tvalid=0, m_axis_tlast=0; buffer contents need not be cleared.
REQ-026 SHALL assert s_axis_tready on the first clk edge after rst deasserts.
REQ-027 SHALL discard all stored words, including partial frames, on reset mid-operation.

Configuration
REQ-028 SHALL compile store-and-forward mode when macro AXIS_FRAME_FIFO_STORE_FWD_EN is defined: m_axis_tvalid = !empty && (frame_count != 0 || full || frame in progress at output).
REQ-029 SHALL, in store-and-forward mode, once first word of a frame is read, keep presenting that frame until its tlast is read (frame-in-progress flag, cleared on tlast read and reset).
REQ-030 SHALL, in store-and-forward mode with FIFO full and frame_count==0, release words cut-through to prevent deadlock.
REQ-031 SHALL, without the macro, operate cut-through: m_axis_tvalid = !empty.

Verification
REQ-032 SHALL verify: reset release, write 3 words (A,B,C; C tlast) with m_axis_tready=1 -> A out cycle after write, order A,B,C, tlast only on C, fill_level returns 0.
REQ-033 SHALL verify: m_axis_tready=0, write DEPTH words -> s_axis_tready low after 16th write, fill_level=16, 17th word not accepted; then read one -> tready high next cycle.
REQ-034 SHALL verify: full FIFO, s_axis_tvalid and m_axis_tready held 1 -> steady 1 word/2 cycles max, no loss, pointers wrap correctly over 40 words.
REQ-035 SHALL verify: with STORE_FWD_EN, write 5 words without tlast -> m_axis_tvalid stays 0; write 6th with tlast -> tvalid next cycle, frame_count=1, six words out, frame_count=0.
REQ-036 SHALL verify: with STORE_FWD_EN, 16 words no tlast -> full-release drains words; without macro, same stimulus -> tvalid one cycle after first write.
REQ-037 SHALL verify: rst pulsed mid-frame with fill_level=7 -> outputs cleared immediately (asynchronously), fill_level=0, frame_count=0, no stale word emitted afterwards.
